// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
// Optional priority qualifier is enabled by defining RR_ARB_PRIO_EN.
package arb_pkg;

    localparam int ARB_MIN_N     = 2;
    localparam int ARB_MAX_N     = 64;
    localparam int ARB_IDX_MAX_W = 6;
    localparam int ARB_CNT_MAX_W = 16;

    // Fields are sized for the largest supported configuration and zero-extended by the top.
    typedef struct packed {
        logic [ARB_IDX_MAX_W-1:0] last_ptr;
        logic [ARB_CNT_MAX_W-1:0] burst_cnt;
    } arb_state_t;

    function automatic logic [ARB_IDX_MAX_W-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        logic [ARB_IDX_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) r = r | ARB_IDX_MAX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_first.sv
// Cyclic first-set search: finds the lowest set mask bit at or after start+1, wrapping at N.
module rr_pick_first
    import arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [2*N-1:0]           dbl;
    logic [N-1:0]             rot;
    logic [N-1:0]             lowest;
    logic [ARB_IDX_MAX_W-1:0] off;
    int                       base;

    // Rotate so the search origin lands at bit 0, then isolate the lowest set bit.
    always_comb begin
        base   = (int'(start) + 1) % N;
        dbl    = {mask, mask};
        rot    = N'(dbl >> base);
        lowest = rot & (~rot + N'(1));
        off    = onehot_to_idx(ARB_MAX_N'(lowest));
        idx    = IDX_W'((base + int'(off)) % N);
        found  = |mask;
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant and burst-hold limit.
// Define RR_ARB_PRIO_EN to add the prio_req high-priority qualifier.
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter  int N         = 4,
    parameter  int MAX_BURST = 1,
    localparam int IDX_W     = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
`ifdef RR_ARB_PRIO_EN
    input  logic [N-1:0]     prio_req,
`endif
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output arb_state_t       dbg_state
);

    localparam int                CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(MAX_BURST - 1);

    logic [IDX_W-1:0] last_ptr;
    logic [CNT_W-1:0] burst_cnt;
    logic [N-1:0]     eff;
    logic [N-1:0]     others;
    logic             hold;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    // When any qualified high-priority request exists, only those compete.
    always_comb begin
`ifdef RR_ARB_PRIO_EN
        eff = ((req & prio_req) != '0) ? (req & prio_req) : req;
`else
        eff = req;
`endif
        others = eff & ~(N'(1) << grant_idx);
        hold   = grant_valid && eff[grant_idx] &&
                 ((others == '0) || (burst_cnt < BURST_LAST));
    end

    rr_pick_first #(.N(N)) u_pick (
        .mask  (eff),
        .start (last_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last_ptr    <= IDX_W'(N - 1);
            burst_cnt   <= '0;
        end else if (!pick_found) begin
            grant       <= '0;
            grant_valid <= 1'b0;
        end else if (hold) begin
            // Holding alone saturates, so a newcomer may take over on the very next edge.
            if (burst_cnt != BURST_LAST) burst_cnt <= burst_cnt + CNT_W'(1);
        end else begin
            grant       <= N'(1) << pick_idx;
            grant_valid <= 1'b1;
            grant_idx   <= pick_idx;
            last_ptr    <= pick_idx;
            burst_cnt   <= '0;
        end
    end

    always_comb begin
        dbg_state.last_ptr  = ARB_IDX_MAX_W'(last_ptr);
        dbg_state.burst_cnt = ARB_CNT_MAX_W'(burst_cnt);
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n: two instances (burst 1 and 3) share one request stream.
module tb_rr_arbiter_n;
    import arb_pkg::*;

    localparam int N     = 4;
    localparam int IDX_W = 2;
`ifdef RR_ARB_PRIO_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [N-1:0]     prio_req;
    logic [N-1:0]     grant_a, grant_b;
    logic             gv_a, gv_b;
    logic [IDX_W-1:0] gi_a, gi_b;
    arb_state_t       dbg_a, dbg_b;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q[$];

    // Reference state per instance: tenure = grants in a row to the current owner.
    bit m_valid[2];
    int m_idx[2];
    int m_last[2];
    int m_run[2];

    always #5 clk = ~clk;

    rr_arbiter_n #(.N(N), .MAX_BURST(1)) u_dut_mb1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
`ifdef RR_ARB_PRIO_EN
        .prio_req    (prio_req),
`endif
        .grant       (grant_a),
        .grant_valid (gv_a),
        .grant_idx   (gi_a),
        .dbg_state   (dbg_a)
    );

    rr_arbiter_n #(.N(N), .MAX_BURST(3)) u_dut_mb3 (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
`ifdef RR_ARB_PRIO_EN
        .prio_req    (prio_req),
`endif
        .grant       (grant_b),
        .grant_valid (gv_b),
        .grant_idx   (gi_b),
        .dbg_state   (dbg_b)
    );

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got valid=%0b idx=%0d grant=%b expected valid=%0b idx=%0d grant=%b at %0t",
                     name, act[6], act[5:4], act[3:0], exp[6], exp[5:4], exp[3:0], $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_idx[d]   = 0;
            m_last[d]  = N - 1;
            m_run[d]   = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [N-1:0] r, input logic [N-1:0] p,
                              output logic [6:0] e);
        logic [N-1:0] hp, eff;
        int           mb;
        bit           others;
        mb  = (d == 0) ? 1 : 3;
        hp  = PRIO_EN ? (r & p) : '0;
        eff = (hp != '0) ? hp : r;
        if (eff == '0) begin
            m_valid[d] = 1'b0;
        end else begin
            others = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_idx[d] && eff[i]) others = 1'b1;
            if (m_valid[d] && eff[m_idx[d]] && (!others || m_run[d] < mb)) begin
                if (m_run[d] < mb) m_run[d]++;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (eff[(m_last[d] + k) % N]) begin
                        m_idx[d] = (m_last[d] + k) % N;
                        break;
                    end
                end
                m_last[d]  = m_idx[d];
                m_run[d]   = 1;
                m_valid[d] = 1'b1;
            end
        end
        e = {m_valid[d], IDX_W'(m_idx[d]), m_valid[d] ? (N'(1) << m_idx[d]) : N'(0)};
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] p, input int cycles);
        logic [6:0] ea, eb;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            req      = r;
            prio_req = p;
            model_step(0, req, prio_req, ea);
            model_step(1, req, prio_req, eb);
            exp_q.push_back({ea, eb});
        end
    endtask

    // Monitor: outputs settle one cycle after the stimulus edge.
    initial begin
        logic [13:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_out("mb1_out", {gv_a, gi_a, grant_a}, e[13:7]);
                check_out("mb3_out", {gv_b, gi_b, grant_b}, e[6:0]);
            end
        end
    end

    initial begin
        int wait_cnt;
        reset_n  = 1'b0;
        req      = '0;
        prio_req = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_grant_mb1", int'(grant_a), 0);
        check_val("reset_valid_mb1", int'(gv_a), 0);
        check_val("reset_idx_mb1", int'(gi_a), 0);
        check_val("reset_ptr_mb1", int'(dbg_a.last_ptr), N - 1);
        check_val("reset_grant_mb3", int'(grant_b), 0);
        check_val("reset_cnt_mb3", int'(dbg_b.burst_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;

        drive(4'b0000, 4'b0000, 5);
        drive(4'b1111, 4'b0000, 6);
        drive(4'b0011, 4'b0000, 7);
        drive(4'b0001, 4'b0000, 3);
        drive(4'b0011, 4'b0000, 2);
        drive(4'b0010, 4'b0000, 2);
        drive(4'b1000, 4'b0000, 2);
        drive(4'b0100, 4'b0000, 2);

        // Asynchronous reset while requester 2 owns the grant.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_grant_mb1", int'(grant_a), 0);
        check_val("async_rst_valid_mb1", int'(gv_a), 0);
        check_val("async_rst_grant_mb3", int'(grant_b), 0);
        check_val("async_rst_idx_mb3", int'(gi_b), 0);
        model_reset();
        req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        drive(4'b1111, 4'b0000, 4);

        drive(4'b1111, 4'b0000, 1);
        drive(4'b1111, 4'b0100, 3);
        drive(4'b1111, 4'b0000, 3);
        drive(4'b0101, 4'b0011, 2);

        for (int i = 0; i < 150; i++) begin
            logic [N-1:0] r, p;
            r = N'($urandom_range(0, 15));
            p = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            drive(r, p, $urandom_range(1, 4));
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
